// File: rtl/msdap_pkg.sv
// Shared MSDAP constants and types: default word width, output-serializer
// state encoding, and the error-flag layout that main_controller reads.
package msdap_pkg;

    localparam int MSDAP_WIDTH = 40;
    localparam int MSDAP_CNT_W = 6;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    // Bit positions inside the sticky flag vector exported to main_controller.
    localparam int FLAG_OVERRUN_BIT  = 0;
    localparam int FLAG_UNDERRUN_BIT = 1;
    localparam int FLAG_W            = 2;

    typedef logic [FLAG_W-1:0] ser_flags_t;

    function automatic ser_flags_t pack_flags(input logic ovr, input logic und);
        ser_flags_t f;
        f                    = '0;
        f[FLAG_OVERRUN_BIT]  = ovr;
        f[FLAG_UNDERRUN_BIT] = und;
        return f;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter, MSB first; msb_o is a register bit.
// Latency: loaded MSB visible the edge after load_i; one bit per shift_i edge.
// Backpressure: none; the caller sequences load/shift, clr_i has priority.
module piso_shift #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (load_i) begin
            shift_d = data_i;
        end else if (shift_i) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign msb_o = shift_q[WIDTH-1];

endmodule

// File: rtl/output_serializer.sv
// Serializes 40-bit L/R result pairs onto OutputL/OutputR, one pair per Frame.
// Latency: MSB driven on the edge that samples the Frame rise; WIDTH bits follow.
// Backpressure: none; a single holding slot, overwrite flags overrun, empty Frame flags underrun.
module output_serializer
    import msdap_pkg::*;
#(
    parameter int WIDTH = MSDAP_WIDTH,
    parameter int CNT_W = MSDAP_CNT_W
) (
    input  logic             Sclk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             Frame,
    input  logic             sum_valid,
    input  logic [WIDTH-1:0] sumL,
    input  logic [WIDTH-1:0] sumR,
    output logic             OutputL,
    output logic             OutputR,
    output logic             OutReady,
    output logic             busy,
    output logic             overrun,
    output logic             underrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_d_q;
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;
    logic             pending_q, pending_d;
    ser_flags_t       flags_q, flags_d;

    logic             frame_rise;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_clr;
    logic             ovr_set;
    logic             und_set;

    assign frame_rise = Frame & ~frame_d_q;

    // Control FSM: IDLE waits for a Frame rise, SHIFT counts WIDTH bits out.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clr   = 1'b0;
        und_set  = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (frame_rise) begin
                    if (pending_q) begin
                        sh_load = 1'b1;
                        cnt_d   = CNT_LAST;
                        state_d = SER_SHIFT;
                    end else begin
                        und_set = 1'b1;
                    end
                end
            end
            SER_SHIFT: begin
                if (cnt_q == '0) begin
                    sh_clr  = 1'b1;
                    state_d = SER_IDLE;
                end else begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase
        if (Clear) begin
            state_d  = SER_IDLE;
            cnt_d    = '0;
            sh_load  = 1'b0;
            sh_shift = 1'b0;
            sh_clr   = 1'b1;
            und_set  = 1'b0;
        end
    end

    // Holding slot: a load on the same edge frees the slot, so no overrun then.
    always_comb begin
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
        pending_d = pending_q;
        ovr_set   = 1'b0;
        if (sum_valid) begin
            hold_l_d  = sumL;
            hold_r_d  = sumR;
            pending_d = 1'b1;
            ovr_set   = pending_q & ~sh_load;
        end else if (sh_load) begin
            pending_d = 1'b0;
        end
        flags_d = flags_q | pack_flags(ovr_set, und_set);
        if (Clear) begin
            hold_l_d  = '0;
            hold_r_d  = '0;
            pending_d = 1'b0;
            flags_d   = '0;
        end
    end

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= SER_IDLE;
            cnt_q     <= '0;
            frame_d_q <= 1'b0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            pending_q <= 1'b0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_d_q <= Clear ? 1'b0 : Frame;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            pending_q <= pending_d;
            flags_q   <= flags_d;
        end
    end

    // The shifters hold zero whenever idle, so their MSB taps are the pins.
    piso_shift #(.WIDTH(WIDTH)) u_piso_l (
        .clk     (Sclk),
        .rst_n   (Reset_n),
        .clr_i   (sh_clr),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (hold_l_q),
        .msb_o   (OutputL)
    );

    piso_shift #(.WIDTH(WIDTH)) u_piso_r (
        .clk     (Sclk),
        .rst_n   (Reset_n),
        .clr_i   (sh_clr),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (hold_r_q),
        .msb_o   (OutputR)
    );

    assign OutReady = (state_q == SER_SHIFT);
    assign busy     = (state_q == SER_SHIFT);
    assign overrun  = flags_q[FLAG_OVERRUN_BIT];
    assign underrun = flags_q[FLAG_UNDERRUN_BIT];

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed word, length and flag expectations.
module tb_output_serializer;

    localparam int W = 40;

    logic         Sclk = 1'b0;
    logic         Reset_n, Clear, Frame, sum_valid;
    logic [W-1:0] sumL, sumR;
    logic         OutputL, OutputR, OutReady, busy, overrun, underrun;

    always #5 Sclk = ~Sclk;

    output_serializer dut (
        .Sclk      (Sclk),
        .Reset_n   (Reset_n),
        .Clear     (Clear),
        .Frame     (Frame),
        .sum_valid (sum_valid),
        .sumL      (sumL),
        .sumR      (sumR),
        .OutputL   (OutputL),
        .OutputR   (OutputR),
        .OutReady  (OutReady),
        .busy      (busy),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a pending word slot and a queue of bit pairs still to show.
    bit           m_rdy, m_l, m_r, m_ovr, m_und, m_pend, m_fprev;
    logic [W-1:0] m_hl, m_hr;
    logic [1:0]   mq[$];

    logic [W-1:0] capL = '0, capR = '0;
    int           run_len = 0, last_run = 0;

    initial begin
        m_rdy = 0; m_l = 0; m_r = 0; m_ovr = 0; m_und = 0; m_pend = 0; m_fprev = 0;
        m_hl = '0; m_hr = '0;
        forever begin
            bit rise, loaded;
            @(posedge Sclk);
            if (!Reset_n || Clear) begin
                m_rdy = 0; m_l = 0; m_r = 0; m_ovr = 0; m_und = 0; m_pend = 0; m_fprev = 0;
                m_hl = '0; m_hr = '0;
                mq.delete();
            end else begin
                rise    = Frame && !m_fprev;
                m_fprev = Frame;
                loaded  = 0;
                if (m_rdy) begin
                    if (mq.size() > 0) {m_l, m_r} = mq.pop_front();
                    else begin m_rdy = 0; m_l = 0; m_r = 0; end
                end else if (rise) begin
                    if (m_pend) begin
                        for (int i = W - 1; i >= 0; i--) mq.push_back({m_hl[i], m_hr[i]});
                        {m_l, m_r} = mq.pop_front();
                        m_rdy  = 1;
                        loaded = 1;
                    end else begin
                        m_und = 1;
                    end
                end
                if (sum_valid) begin
                    if (m_pend && !loaded) m_ovr = 1;
                    m_hl   = sumL;
                    m_hr   = sumR;
                    m_pend = 1;
                end else if (loaded) begin
                    m_pend = 0;
                end
            end
            #1;
            check("cyc OutReady", 64'(OutReady), 64'(m_rdy));
            check("cyc busy",     64'(busy),     64'(m_rdy));
            check("cyc OutputL",  64'(OutputL),  64'(m_l));
            check("cyc OutputR",  64'(OutputR),  64'(m_r));
            check("cyc overrun",  64'(overrun),  64'(m_ovr));
            check("cyc underrun", 64'(underrun), 64'(m_und));
            if (OutReady) begin
                capL = {capL[W-2:0], OutputL};
                capR = {capR[W-2:0], OutputR};
                run_len++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Sclk);
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        sumL = l; sumR = r; sum_valid = 1'b1;
        cyc(1);
        sum_valid = 1'b0;
    endtask

    task automatic frame_pulse();
        Frame = 1'b1;
        cyc(1);
        Frame = 1'b0;
    endtask

    task automatic clear_pulse();
        Clear = 1'b1;
        cyc(1);
        Clear = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Clear = 1'b0; Frame = 1'b0; sum_valid = 1'b0;
        sumL = '0; sumR = '0;
        cyc(2);
        check("rst OutReady", 64'(OutReady), 64'd0);
        check("rst busy",     64'(busy),     64'd0);
        check("rst OutputL",  64'(OutputL),  64'd0);
        check("rst flags",    64'({overrun, underrun}), 64'd0);
        Reset_n = 1'b1;
        cyc(2);

        // Basic word
        send(40'h80_0000_0001, 40'h00_0000_0003);
        frame_pulse();
        cyc(44);
        check("basic L word", 64'(capL), 64'h80_0000_0001);
        check("basic R word", 64'(capR), 64'h00_0000_0003);
        check("basic OutReady len", 64'(last_run), 64'd40);
        check("basic flags", 64'({overrun, underrun}), 64'd0);

        // Underrun then normal transmission
        frame_pulse();
        cyc(3);
        check("under flag", 64'(underrun), 64'd1);
        check("under no ready", 64'(OutReady), 64'd0);
        send(40'h12_3456_789A, 40'hFE_DCBA_9876);
        frame_pulse();
        cyc(44);
        check("under L word", 64'(capL), 64'h12_3456_789A);
        check("under R word", 64'(capR), 64'hFE_DCBA_9876);
        check("under sticky", 64'(underrun), 64'd1);
        clear_pulse();
        check("clear flags", 64'({overrun, underrun}), 64'd0);

        // Overrun: second sum replaces the first
        send(40'h1, 40'h1);
        send(40'h2, 40'h2);
        check("over flag", 64'(overrun), 64'd1);
        frame_pulse();
        cyc(44);
        check("over L word", 64'(capL), 64'h2);
        check("over R word", 64'(capR), 64'h2);
        clear_pulse();

        // Coincident load: D shifts out, C waits for the next Frame
        send(40'hD0_0000_000D, 40'h0D_0000_00D0);
        sumL = 40'hC0_FFEE_000C; sumR = 40'h0C_1234_00C0; sum_valid = 1'b1; Frame = 1'b1;
        cyc(1);
        sum_valid = 1'b0; Frame = 1'b0;
        cyc(44);
        check("coin first L", 64'(capL), 64'hD0_0000_000D);
        check("coin first R", 64'(capR), 64'h0D_0000_00D0);
        check("coin no overrun", 64'(overrun), 64'd0);
        frame_pulse();
        cyc(44);
        check("coin second L", 64'(capL), 64'hC0_FFEE_000C);
        check("coin second R", 64'(capR), 64'h0C_1234_00C0);
        check("coin no underrun", 64'(underrun), 64'd0);
        clear_pulse();

        // Mid-shift abort by reset after 17 bits
        send(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
        frame_pulse();
        cyc(16);
        Reset_n = 1'b0;
        #1;
        check("abort OutReady", 64'(OutReady), 64'd0);
        check("abort OutputL",  64'(OutputL),  64'd0);
        check("abort OutputR",  64'(OutputR),  64'd0);
        cyc(2);
        check("abort bit count", 64'(last_run), 64'd17);
        Reset_n = 1'b1;
        cyc(1);
        frame_pulse();
        cyc(2);
        check("abort underrun", 64'(underrun), 64'd1);
        check("abort no ready", 64'(OutReady), 64'd0);
        clear_pulse();

        // Frame rise during SHIFT is ignored
        send(40'hA5_5A00_FF3C, 40'h3C_FF00_5AA5);
        frame_pulse();
        cyc(9);
        frame_pulse();
        cyc(40);
        check("ign OutReady len", 64'(last_run), 64'd40);
        check("ign L word", 64'(capL), 64'hA5_5A00_FF3C);
        check("ign R word", 64'(capR), 64'h3C_FF00_5AA5);
        check("ign no underrun", 64'(underrun), 64'd0);
        check("ign no restart", 64'(OutReady), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
